multi_square_wave_gen: RTL

//  Parametrised multi-channel successor to the fixed square-wave divider: NUM_CH independent
//  50%-duty square waves, each with a runtime-programmable half-period and enable.

---
 rtl/multi_square_wave_gen_if.sv | 26 ++
 rtl/multi_square_wave_gen.sv | 98 +++++++++
 2 files changed

// File: rtl/multi_square_wave_gen_if.sv
// Config/status bundle for multi_square_wave_gen: the config master drives the
// write strobe, channel, divider, enable and sync, and receives the per-channel wave outputs.
interface multi_square_wave_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic              cfg_wr;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              sync;
   logic [NUM_CH-1:0] square_wave;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] upd_pend;

   modport master (
      output cfg_wr, cfg_ch, cfg_div, cfg_en, sync,
      input  square_wave, rise, upd_pend
   );

   modport slave (
      input  cfg_wr, cfg_ch, cfg_div, cfg_en, sync,
      output square_wave, rise, upd_pend
   );
endinterface

// File: rtl/multi_square_wave_gen.sv
// NUM_CH independent 50%-duty square waves with runtime half-period and enable.
// Divider changes are staged and take effect only at a half-period boundary.
module multi_square_wave_gen #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multi_square_wave_gen_if.slave bus
);
   localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [NUM_CH-1:0] en_p0;
   logic [NUM_CH-1:0] wave_p0;
   logic [NUM_CH-1:0] rise_p0;
   logic [NUM_CH-1:0] pend_p0;
   logic [CNT_W-1:0]  cnt_p0    [NUM_CH];
   logic [CNT_W-1:0]  active_p0 [NUM_CH];
   logic [CNT_W-1:0]  staged_p0 [NUM_CH];
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] term;

   // A zero divider behaves as one so the terminal compare never wraps.
   function automatic logic [CNT_W-1:0] neff(input logic [CNT_W-1:0] d);
      return (d == '0) ? CNT_W'(1) : d;
   endfunction

   always_comb begin
      hit  = '0;
      term = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]  = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));
         term[i] = (cnt_p0[i] == (neff(active_p0[i]) - CNT_W'(1)));
      end
   end

   // ---- state stage: priority reset > disable > sync > enable > terminal > count
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            en_p0[i]     <= 1'b0;
            cnt_p0[i]    <= '0;
            wave_p0[i]   <= 1'b0;
            rise_p0[i]   <= 1'b0;
            pend_p0[i]   <= 1'b0;
            active_p0[i] <= DIV_RST;
            staged_p0[i] <= DIV_RST;
         end else if (hit[i] && !bus.cfg_en) begin
            en_p0[i]     <= 1'b0;
            cnt_p0[i]    <= '0;
            wave_p0[i]   <= 1'b0;
            rise_p0[i]   <= 1'b0;
            pend_p0[i]   <= 1'b0;
            active_p0[i] <= bus.cfg_div;
            staged_p0[i] <= bus.cfg_div;
         end else if (bus.sync && en_p0[i]) begin
            cnt_p0[i]    <= '0;
            wave_p0[i]   <= 1'b0;
            rise_p0[i]   <= 1'b0;
            pend_p0[i]   <= 1'b0;
            active_p0[i] <= hit[i] ? bus.cfg_div : staged_p0[i];
            staged_p0[i] <= hit[i] ? bus.cfg_div : staged_p0[i];
         end else if (hit[i] && !en_p0[i]) begin
            en_p0[i]     <= 1'b1;
            cnt_p0[i]    <= '0;
            wave_p0[i]   <= 1'b0;
            rise_p0[i]   <= 1'b0;
            pend_p0[i]   <= 1'b0;
            active_p0[i] <= bus.cfg_div;
            staged_p0[i] <= bus.cfg_div;
         end else if (en_p0[i]) begin
            if (term[i]) begin
               // A write landing on the boundary bypasses staging and applies at once.
               cnt_p0[i]    <= '0;
               wave_p0[i]   <= ~wave_p0[i];
               rise_p0[i]   <= ~wave_p0[i];
               pend_p0[i]   <= 1'b0;
               active_p0[i] <= hit[i] ? bus.cfg_div : staged_p0[i];
            end else begin
               cnt_p0[i]  <= cnt_p0[i] + CNT_W'(1);
               rise_p0[i] <= 1'b0;
               if (hit[i]) pend_p0[i] <= 1'b1;
            end
            if (hit[i]) staged_p0[i] <= bus.cfg_div;
         end else begin
            cnt_p0[i]  <= '0;
            wave_p0[i] <= 1'b0;
            rise_p0[i] <= 1'b0;
         end
      end
   end

   assign bus.square_wave = wave_p0;
   assign bus.rise        = rise_p0;
   assign bus.upd_pend    = pend_p0;
endmodule
